// File: rtl/pc_sequencer_if.sv
// Run-control bus between the test harness / decoder side and the PC sequencer.
// The master drives the run-control and branch inputs; the sequencer (slave) drives the fetch address and status.
interface pc_sequencer_if #(
    parameter int PC_W  = 10,
    parameter int CYC_W = 16
);
    logic             start;
    logic             stall;
    logic             branch_en;
    logic             branch_rel;
    logic [PC_W-1:0]  branch_tgt;
    logic             halt;
    logic [PC_W-1:0]  prog_ct;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CYC_W-1:0] cycle_ct;

    modport master (
        output start, stall, branch_en, branch_rel, branch_tgt, halt,
        input  prog_ct, running, done, timeout, cycle_ct
    );

    modport slave (
        input  start, stall, branch_en, branch_rel, branch_tgt, halt,
        output prog_ct, running, done, timeout, cycle_ct
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter and run-control sequencer: IDLE/RUN/DONE with stall, absolute/relative
// branching, halt completion and a cycle-budget timeout; all status outputs are registered.
module pc_sequencer #(
    parameter int                 PC_W     = 10,
    parameter int                 CYC_W    = 16,
    parameter int unsigned        MAX_CYC  = 16'hFFFF,
    parameter logic [PC_W-1:0]    START_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Budget check fires on the last allowed cycle, so cycle_ct tops out at MAX_CYC and never wraps.
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(MAX_CYC - 1);

    state_t           r_state;
    logic             r_start_d;
    logic [PC_W-1:0]  r_pc;
    logic [CYC_W-1:0] r_cyc;
    logic             r_running;
    logic             r_done;
    logic             r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b0;
            r_pc      <= START_PC;
            r_cyc     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_start_d <= bus.start;
            if (bus.start) begin
                r_state   <= S_IDLE;
                r_pc      <= START_PC;
                r_cyc     <= '0;
                r_running <= 1'b0;
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_start_d) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        r_cyc <= r_cyc + CYC_W'(1);
                        if (bus.halt) begin
                            r_state   <= S_DONE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                            r_timeout <= 1'b0;
                        end else if (r_cyc == LAST_CYC) begin
                            r_state   <= S_DONE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                            r_timeout <= 1'b1;
                        end else if (bus.stall) begin
                            r_pc <= r_pc;
                        end else if (bus.branch_en) begin
                            // Equal-width add gives the signed relative offset modulo 2^PC_W.
                            r_pc <= bus.branch_rel ? (r_pc + bus.branch_tgt) : bus.branch_tgt;
                        end else begin
                            r_pc <= r_pc + PC_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                        r_done    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.prog_ct  = r_pc;
    assign bus.cycle_ct = r_cyc;
    assign bus.running  = r_running;
    assign bus.done     = r_done;
    assign bus.timeout  = r_timeout;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter and run-control sequencer; drives the instruction-fetch address for the processor core.
- Replaces the free-running fixed-count counter used on the first-generation DUT.
- Adds stall, absolute and relative branching, halt-driven completion and a cycle-budget timeout.
- Sits between the testbench start/done pins and the instruction ROM/decoder.

Parameters:
- PC_W, 10, program counter width; PC wraps modulo 2^PC_W.
- CYC_W, 16, width of the executed-cycle counter.
- MAX_CYC, 16'hFFFF, cycle budget; reaching it forces completion with timeout. Must be <= 2^CYC_W-1 and >= 1.
- START_PC, 0, PC value loaded while start is high.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, level; while high, sequencer is held at START_PC; falling edge begins run.
- stall, input, 1, freeze PC this cycle (cycle counter still advances).
- branch_en, input, 1, take branch this cycle.
- branch_rel, input, 1, 1 = relative (PC + signed offset), 0 = absolute target.
- branch_tgt, input, PC_W, absolute target or two's-complement offset.
- halt, input, 1, decoder asserts on halt instruction at current PC.
- prog_ct, output, PC_W, current fetch address.
- running, output, 1, high in RUN.
- done, output, 1, high in DONE; sticky until next start.
- timeout, output, 1, high with done when completion was by budget exhaustion.
- cycle_ct, output, CYC_W, RUN cycles elapsed in current program.

Behaviour:
- Reset (rst_n low, async): state IDLE, prog_ct=START_PC, cycle_ct=0, running=0, done=0, timeout=0.
- States: IDLE, RUN, DONE; done/running/timeout are registered, decoded from state.
- Any state, start=1: next state IDLE, prog_ct<=START_PC, cycle_ct<=0, timeout<=0. Start overrides all other inputs, including mid-run (restart).
- IDLE, start=0: if previous-cycle start was 1 (falling edge, registered start_d), go RUN; else stay IDLE. Reset-released IDLE with start never asserted stays IDLE.
- RUN, per cycle, evaluated against current prog_ct:
  - cycle_ct <= cycle_ct+1 every RUN cycle (stalled or not).
  - halt=1: go DONE; prog_ct holds; cycle_ct still increments (counts halt cycle); timeout=0. Halt has priority over branch/stall and over budget.
  - else cycle_ct == MAX_CYC-1: go DONE with timeout=1; prog_ct holds.
  - else stall=1: prog_ct holds (branch ignored).
  - else branch_en=1, branch_rel=0: prog_ct <= branch_tgt.
  - else branch_en=1, branch_rel=1: prog_ct <= prog_ct + branch_tgt, modulo 2^PC_W (sign-extension irrelevant at equal width).
  - else prog_ct <= prog_ct+1, wrapping from 2^PC_W-1 to 0.
- DONE: all outputs frozen; stall/branch/halt ignored; leave only on start=1 (to IDLE) or reset.
- First RUN cycle presents prog_ct=START_PC; no bubble.
- cycle_ct never wraps: budget stop precedes overflow.

Test Plan:
- Reset then start high 2 cycles, low; no other input -> running=1 next cycle, prog_ct 0,1,2,...,9 on successive cycles, cycle_ct tracks 0..9.
- RUN at prog_ct=5: absolute branch_tgt=0x3F0 -> prog_ct=0x3F0 next cycle. Then relative tgt=0x3FE (-2) -> 0x3EE. At 0x3FF with increment -> 0x000.
- RUN, stall=1 with branch_en=1 for 3 cycles at prog_ct=7 -> prog_ct stays 7, cycle_ct advances by 3; release -> 8.
- halt=1 at prog_ct=12 after 12 cycles -> done=1, timeout=0, running=0, prog_ct=12, cycle_ct=13. Remains frozen 20 cycles despite toggling branch/stall.
- MAX_CYC=20, no halt -> after 20 RUN cycles done=1, timeout=1, cycle_ct=20. halt and budget in same cycle -> timeout=0.
- Start pulsed mid-RUN at prog_ct=30 -> IDLE, prog_ct=0, cycle_ct=0, done=0. rst_n low mid-DONE -> all outputs 0 immediately, without waiting for clock edge.
